// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the program counter, fetches one instruction word
// over a req/ack memory handshake with timeout, and holds it in the instruction register.
module instr_fetch_unit #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_fetch_pulse,
  input  logic              en_pc_pulse,
  input  logic [1:0]        pc_ctrl,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir,
  output logic [3:0]        opcode,
  output logic [1:0]        rd,
  output logic [1:0]        rs,
  output logic [7:0]        imm,
  output logic              en1,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              fetch_err
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] tmo_cnt;

  function automatic logic [ADDR_W-1:0] next_pc(
    input logic [ADDR_W-1:0] cur,
    input logic [1:0]        ctrl,
    input logic [ADDR_W-1:0] target
  );
    logic [ADDR_W-1:0] res;
    case (ctrl)
      2'b01:   res = cur + ADDR_W'(1);
      2'b10:   res = target;
      2'b11:   res = '0;
      default: res = cur;
    endcase
    return res;
  endfunction

  // PC updates run independently of the fetch FSM; a same-edge fetch latches the old value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= '0;
    end else if (en_pc_pulse) begin
      pc <= next_pc(pc, pc_ctrl, jump_addr);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      busy      <= 1'b0;
      en1       <= 1'b0;
      fetch_err <= 1'b0;
      tmo_cnt   <= '0;
      ir        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (en_fetch_pulse) begin
            mem_addr  <= pc;
            mem_req   <= 1'b1;
            busy      <= 1'b1;
            en1       <= 1'b0;
            fetch_err <= 1'b0;
            tmo_cnt   <= '0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Ack wins over timeout when both land on the last allowed cycle.
          if (mem_ack) begin
            ir      <= mem_rdata;
            en1     <= 1'b1;
            mem_req <= 1'b0;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            mem_req   <= 1'b0;
            busy      <= 1'b0;
            fetch_err <= 1'b1;
            state     <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign opcode = ir[15:12];
  assign rd     = ir[11:10];
  assign rs     = ir[9:8];
  assign imm    = ir[7:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: randomized fetches and PC updates
// compared against a transaction-level model of pc, ir and status flags.
module tb_instr_fetch_unit;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              en_fetch_pulse = 1'b0;
  logic              en_pc_pulse = 1'b0;
  logic [1:0]        pc_ctrl = 2'b00;
  logic [ADDR_W-1:0] jump_addr = '0;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [DATA_W-1:0] ir;
  logic [3:0]        opcode;
  logic [1:0]        rd;
  logic [1:0]        rs;
  logic [7:0]        imm;
  logic              en1;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              fetch_err;

  instr_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .en_fetch_pulse(en_fetch_pulse), .en_pc_pulse(en_pc_pulse),
    .pc_ctrl(pc_ctrl), .jump_addr(jump_addr), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ir(ir), .opcode(opcode), .rd(rd), .rs(rs),
    .imm(imm), .en1(en1), .pc(pc), .busy(busy), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model state
  int          m_pc = 0;
  int          m_ir = 0;
  logic [15:0] mem [256];

  function automatic int model_pc(input int cur, input int ctrl, input int target);
    case (ctrl)
      1:       return (cur + 1) % 256;
      2:       return target;
      3:       return 0;
      default: return cur;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Completes one fetch: waits `waits` ack-less cycles, then acks with mem[addr].
  task automatic do_fetch(input int waits, input logic pcp, input logic [1:0] ctrl,
                          input logic [7:0] tgt, input string tag);
    int addr;
    int d;
    addr = m_pc;
    en_fetch_pulse = 1'b1; en_pc_pulse = pcp; pc_ctrl = ctrl; jump_addr = tgt;
    step();
    en_fetch_pulse = 1'b0; en_pc_pulse = 1'b0;
    if (pcp) m_pc = model_pc(m_pc, ctrl, tgt);
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL %s req_start got=%b exp=1", tag, mem_req); end
    total++; if (mem_addr !== addr[7:0]) begin bad++; $display("FAIL %s addr got=%h exp=%h", tag, mem_addr, addr[7:0]); end
    total++; if (pc !== m_pc[7:0]) begin bad++; $display("FAIL %s pc got=%h exp=%h", tag, pc, m_pc[7:0]); end
    total++; if ({busy, en1, fetch_err} !== 3'b100) begin bad++; $display("FAIL %s flags_start got=%b exp=100", tag, {busy, en1, fetch_err}); end
    for (int k = 0; k < waits; k++) begin
      step();
      total++; if (mem_req !== 1'b1 || mem_addr !== addr[7:0] || en1 !== 1'b0) begin
        bad++; $display("FAIL %s wait%0d req=%b addr=%h en1=%b exp req=1 addr=%h en1=0", tag, k, mem_req, mem_addr, en1, addr[7:0]);
      end
    end
    d = int'(mem[addr]);
    mem_ack = 1'b1; mem_rdata = mem[addr];
    step();
    mem_ack = 1'b0; mem_rdata = 16'(($urandom));
    m_ir = d;
    total++; if (ir !== m_ir[15:0]) begin bad++; $display("FAIL %s ir got=%h exp=%h", tag, ir, m_ir[15:0]); end
    total++; if ({opcode, rd, rs, imm} !== {4'((d >> 12) & 15), 2'((d >> 10) & 3), 2'((d >> 8) & 3), 8'(d & 255)}) begin
      bad++; $display("FAIL %s fields got=%h/%h/%h/%h exp ir=%h", tag, opcode, rd, rs, imm, m_ir[15:0]);
    end
    total++; if ({en1, busy, mem_req} !== 3'b100) begin bad++; $display("FAIL %s done got en1,busy,req=%b exp=100", tag, {en1, busy, mem_req}); end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    total++; if ({pc, ir, en1, mem_req, mem_addr, busy, fetch_err} !== '0) begin
      bad++; $display("FAIL reset pc=%h ir=%h en1=%b req=%b addr=%h busy=%b err=%b exp all 0", pc, ir, en1, mem_req, mem_addr, busy, fetch_err);
    end
    rst = 1'b1;
    m_pc = 0; m_ir = 0;
    step();
  endtask

  task automatic test_first_fetch();
    mem[0] = 16'h2A5C;
    do_fetch(0, 1'b1, 2'b01, 8'h00, "first");
    total++; if ({opcode, rd, rs, imm} !== {4'h2, 2'd2, 2'd2, 8'h5C}) begin
      bad++; $display("FAIL first_fixed got=%h/%h/%h/%h exp=2/2/2/5c", opcode, rd, rs, imm);
    end
  endtask

  task automatic test_wait_states();
    do_fetch(3, 1'b0, 2'b00, 8'h00, "wait3");
  endtask

  task automatic test_pc_update();
    int c;
    int t;
    en_pc_pulse = 1'b1; pc_ctrl = 2'b10; jump_addr = 8'hFF; step(); m_pc = 255;
    pc_ctrl = 2'b01; step();
    total++; if (pc !== 8'h00) begin bad++; $display("FAIL pc_wrap got=%h exp=00", pc); end
    pc_ctrl = 2'b10; jump_addr = 8'h40; step();
    total++; if (pc !== 8'h40) begin bad++; $display("FAIL pc_jump got=%h exp=40", pc); end
    pc_ctrl = 2'b11; step();
    total++; if (pc !== 8'h00) begin bad++; $display("FAIL pc_clear got=%h exp=00", pc); end
    pc_ctrl = 2'b00; step();
    total++; if (pc !== 8'h00) begin bad++; $display("FAIL pc_hold got=%h exp=00", pc); end
    m_pc = 0;
    for (int i = 0; i < 20; i++) begin
      c = int'($urandom_range(0, 3)); t = int'($urandom_range(0, 255));
      en_pc_pulse = 1'($urandom_range(0, 1)); pc_ctrl = 2'(c); jump_addr = 8'(t);
      if (en_pc_pulse) m_pc = model_pc(m_pc, c, t);
      step();
      total++; if (pc !== m_pc[7:0]) begin bad++; $display("FAIL pc_rand%0d got=%h exp=%h", i, pc, m_pc[7:0]); end
    end
    en_pc_pulse = 1'b0;
  endtask

  task automatic test_timeout();
    int cnt;
    int addr;
    addr = m_pc;
    en_fetch_pulse = 1'b1; step(); en_fetch_pulse = 1'b0;
    cnt = 0;
    for (int k = 0; k < 40 && mem_req === 1'b1; k++) begin cnt++; step(); end
    total++; if (cnt != TIMEOUT) begin bad++; $display("FAIL tmo_cycles got=%0d exp=%0d", cnt, TIMEOUT); end
    total++; if ({fetch_err, en1, busy} !== 3'b100) begin bad++; $display("FAIL tmo_flags got err,en1,busy=%b exp=100", {fetch_err, en1, busy}); end
    total++; if (ir !== m_ir[15:0]) begin bad++; $display("FAIL tmo_ir got=%h exp=%h", ir, m_ir[15:0]); end
    step();
    total++; if (fetch_err !== 1'b1) begin bad++; $display("FAIL tmo_sticky got=%b exp=1", fetch_err); end
    do_fetch(int'($urandom_range(0, 4)), 1'b1, 2'b00, 8'h00, "retry");
    total++; if (mem_addr !== addr[7:0]) begin bad++; $display("FAIL retry_addr got=%h exp=%h", mem_addr, addr[7:0]); end
  endtask

  task automatic test_fetch_in_wait();
    int addr;
    addr = m_pc;
    en_fetch_pulse = 1'b1; step(); en_fetch_pulse = 1'b0;
    step();
    en_fetch_pulse = 1'b1; en_pc_pulse = 1'b1; pc_ctrl = 2'b10; jump_addr = 8'h10;
    step();
    en_fetch_pulse = 1'b0; en_pc_pulse = 1'b0; m_pc = 16;
    total++; if (mem_addr !== addr[7:0] || mem_req !== 1'b1) begin
      bad++; $display("FAIL inwait_addr got=%h req=%b exp=%h req=1", mem_addr, mem_req, addr[7:0]);
    end
    total++; if (pc !== 8'h10) begin bad++; $display("FAIL inwait_pc got=%h exp=10", pc); end
    mem_ack = 1'b1; mem_rdata = mem[addr]; step(); mem_ack = 1'b0;
    m_ir = int'(mem[addr]);
    total++; if (ir !== m_ir[15:0] || en1 !== 1'b1) begin bad++; $display("FAIL inwait_ir got=%h en1=%b exp=%h en1=1", ir, en1, m_ir[15:0]); end
    mem_ack = 1'b1; mem_rdata = ~mem[addr];
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (mem_req !== 1'b0 || busy !== 1'b0 || ir !== m_ir[15:0]) begin
        bad++; $display("FAIL inwait_extra%0d req=%b busy=%b ir=%h exp 0 0 %h", k, mem_req, busy, ir, m_ir[15:0]);
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 25; i++) begin
      do_fetch(int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               8'($urandom_range(0, 255)), "b2b");
    end
  endtask

  task automatic test_reset_mid();
    en_fetch_pulse = 1'b1; en_pc_pulse = 1'b1; pc_ctrl = 2'b01; step();
    en_fetch_pulse = 1'b0; en_pc_pulse = 1'b0;
    step(); step();
    #2 rst = 1'b0;
    #1;
    total++; if ({mem_req, busy, en1, pc, ir} !== '0) begin
      bad++; $display("FAIL rst_mid req=%b busy=%b en1=%b pc=%h ir=%h exp all 0", mem_req, busy, en1, pc, ir);
    end
    step();
    rst = 1'b1;
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    step(); step();
    mem_ack = 1'b0;
    total++; if (ir !== 16'h0000 || en1 !== 1'b0) begin bad++; $display("FAIL late_ack ir=%h en1=%b exp=0000 0", ir, en1); end
    m_pc = 0; m_ir = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    test_reset();
    test_first_fetch();
    test_wait_states();
    test_pc_update();
    test_timeout();
    test_fetch_in_wait();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
